// File: rtl/io_uart_tx_if.sv
// Port-bus bundle between the CPU io port and the UART transmitter.
// The CPU drives addr/data/write; the transmitter returns registered data_out.
interface io_uart_tx_if;
    logic [15:0] addr;
    logic [15:0] data;
    logic        write;
    logic [15:0] data_out;

    modport master (
        output addr,
        output data,
        output write,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data,
        input  write,
        output data_out
    );
endinterface

// File: rtl/io_uart_tx.sv
// Port-mapped UART transmitter: byte FIFO, status/divisor/frame registers, 8N1 line.
// Define IO_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module io_uart_tx #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    io_uart_tx_if.slave bus,
    output logic        tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] PTR_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef IO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic        r_wr_prev;
    logic [15:0] r_addr_prev;
    logic [15:0] r_data_prev;
    logic        r_ovf;
    logic [15:0] r_baud;
    logic [15:0] r_frames;
    logic [15:0] r_dout;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;

    state_t      r_state;
    logic        r_tx;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;
    logic [15:0] r_timer;
    logic [15:0] r_div_lat;

    logic [15:0] w_off;
    logic        w_sel;
    logic        w_commit;
    logic        w_wr_tx;
    logic        w_wr_stat;
    logic        w_wr_div;
    logic        w_wr_frm;
    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_busy;
    logic        w_bit_end;
    logic        w_frame_end;
    logic        w_pop;
    logic        w_push;
    logic [7:0]  w_head;
    logic [15:0] w_rdata;

    assign w_off = bus.addr - BASE_ADDR;
    assign w_sel = (w_off[15:2] == 14'd0);

    // Write is a held level: only a fresh or changed access commits.
    assign w_commit = bus.write &&
                      (!r_wr_prev ||
                       (bus.addr != r_addr_prev) ||
                       (bus.data != r_data_prev));

    assign w_wr_tx   = w_commit && w_sel && (w_off[1:0] == 2'd0);
    assign w_wr_stat = w_commit && w_sel && (w_off[1:0] == 2'd1);
    assign w_wr_div  = w_commit && w_sel && (w_off[1:0] == 2'd2);
    assign w_wr_frm  = w_commit && w_sel && (w_off[1:0] == 2'd3);

    assign w_count = r_wp - r_rp;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == PTR_FULL);
    assign w_busy  = (r_state != S_IDLE);
    assign w_head  = r_mem[r_rp[AW-1:0]];

    assign w_bit_end   = (r_timer == 16'd0);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end;
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || w_frame_end);
    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign w_push = w_wr_tx && (!w_full || w_pop);

    always_comb begin
        w_rdata = 16'h0000;
        if (w_sel) begin
            unique case (w_off[1:0])
                2'd1:    w_rdata = {8'(w_count), 4'h0,
                                    r_ovf, w_busy, w_empty, w_full};
                2'd2:    w_rdata = r_baud;
                2'd3:    w_rdata = r_frames;
                default: w_rdata = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= bus.data[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_prev   <= 1'b0;
            r_addr_prev <= 16'h0000;
            r_data_prev <= 16'h0000;
            r_wp        <= '0;
            r_ovf       <= 1'b0;
            r_baud      <= DEFAULT_DIV;
            r_dout      <= 16'h0000;
        end else begin
            r_wr_prev   <= bus.write;
            r_addr_prev <= bus.addr;
            r_data_prev <= bus.data;
            r_dout      <= w_rdata;
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_wr_tx && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_div) begin
                r_baud <= bus.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_timer   <= 16'd0;
            r_div_lat <= 16'd0;
            r_rp      <= '0;
            r_frames  <= 16'h0000;
        end else begin
            if (w_wr_frm) begin
                r_frames <= 16'h0000;
            end else if (w_frame_end) begin
                r_frames <= r_frames + 16'd1;
            end

            // Each frame latches its own divisor at the pop.
            if (w_pop) begin
                r_rp      <= r_rp + PTR_ONE;
                r_shift   <= w_head;
                r_timer   <= r_baud;
                r_div_lat <= r_baud;
                r_bitcnt  <= 3'd0;
                r_tx      <= 1'b0;
                r_state   <= S_START;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_timer  <= r_div_lat;
                            r_bitcnt <= 3'd0;
                            r_tx     <= r_shift[0];
                            r_state  <= S_DATA;
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_timer <= r_div_lat;
                            if (r_bitcnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                                // Rotation preserves the XOR of the byte.
                                r_tx    <= ^r_shift;
                                r_state <= S_PARITY;
`else
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bitcnt <= r_bitcnt + 3'd1;
                                r_shift  <= {r_shift[0], r_shift[7:1]};
                                r_tx     <= r_shift[1];
                            end
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
`ifdef IO_UART_TX_PARITY_EN
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_timer <= r_div_lat;
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (w_bit_end) begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer - 16'd1;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_out = r_dout;
    assign tx           = r_tx;

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial transmitter that answers the CPU's `pst`/`pld` port bus as a responder. It decodes port writes into a byte FIFO and serializes the bytes on a UART-style line. It also exposes status, baud-divisor and overflow registers for polling through port loads. It sits beside the CPU's io port, attached to the same `addr`/`data`/`data_out`/`write` signals.

## Interface
- `BASE_ADDR`, 16'h0000: port address of register 0; the block decodes `BASE_ADDR`..`BASE_ADDR+3`.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of 2, ≥2.
- `DEFAULT_DIV`, 16'd15: reset value of BAUD_DIV.
- `clk`, in, 1: system clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `addr`, in, 16: port address from the CPU.
- `data`, in, 16: port write data.
- `write`, in, 1: level write qualifier, held by the CPU between accesses.
- `data_out`, out, 16: registered read data.
- `tx`, out, 1: serial line output, idle high.

## Operation
- Register map, offset from `BASE_ADDR`:
  - +0 TX_DATA: a write pushes `data[7:0]` into the FIFO. Reads return 0.
  - +1 STATUS: read-only bits, except that a write of any value clears bit3.
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[15:8] FIFO count. All other bits are 0.
  - +2 BAUD_DIV, R/W, 16 bits: one bit period lasts BAUD_DIV+1 cycles.
  - +3 FRAMES, R/W, 16 bits: count of completed frames, wraps at 0xFFFF→0. Any write clears it to 0.
- Unmapped addresses: reads return 0, writes are ignored.
- Write commit: `write` is a level, so a write commits on the edge where all of these hold:
  - `write`=1, and
  - previous-cycle `write`=0, or `addr` differs from its previous-cycle value, or `data` differs from its previous-cycle value.
- Write commit consequences:
  - Repeated identical held writes commit once.
  - To send the same byte twice, software must insert a `pld` (which drops `write`) or any other access between the two writes.
- FIFO full:
  - A TX_DATA commit while full is dropped, sets overflow, and leaves the FIFO unchanged.
  - A push while full on the same edge as an FSM pop is accepted.
- Reads: `data_out` <= mux(`addr`) every cycle, regardless of `write`. Reads have no side effects.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty. This pops a byte into the shift register and latches BAUD_DIV into the bit timer.
  - START: `tx`=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then PARITY (macro) or STOP.
  - PARITY: `tx`=^byte (even parity) for one bit period.
  - STOP: `tx`=1 for one bit period, then the FRAMES increment.
  - After STOP: go to START if the FIFO is non-empty (back-to-back frames, no idle gap), else IDLE.
- BAUD_DIV writes take effect at the next frame start; the current frame keeps its latched divisor.

## Timing
- Reset values:
  - `tx`=1, `data_out`=0.
  - FSM IDLE, FIFO empty, overflow=0, FRAMES=0, BAUD_DIV=`DEFAULT_DIV`.
  - Write-detect history: `write`=0, `addr`=0, `data`=0.
- Asserting `rst_n` mid-frame aborts the frame immediately, with `tx`=1 asynchronously, and discards the FIFO contents.
- Read latency: `data_out` reflects `addr` presented at edge N, updated after edge N. Register updates made at edge N are visible in `data_out` after edge N+1.
- Transmit latency (IDLE, empty FIFO): a TX_DATA commit at edge N makes the FIFO non-empty after N; the pop happens at edge N+1, so `tx` falls after N+1.
- Frame length: 10×(BAUD_DIV+1) cycles, or 11×(BAUD_DIV+1) with parity.
- STATUS/busy:
  - busy=1 from the pop edge to the end of the final STOP.
  - empty=1 as soon as the last byte is popped, even while it is still shifting.

## Configuration
- `IO_UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and frames are 11 bits with even parity.
  - Undefined: the PARITY state is absent and frames are 8N1.
- The register map is identical in both builds.

## Test plan
- Reset, then read +1: `data_out`=0x0002 (empty); `tx`=1.
- Write BAUD_DIV=3, then TX_DATA=0xA5: `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (parity build adds 0 before stop); FRAMES reads 1.
- Hold `write`=1, `addr`=+0, `data`=0x41 for 20 cycles: exactly one frame is sent. A following `pld`, then the same write again, sends a second frame.
- Push 9 bytes while BAUD_DIV=100 with `FIFO_DEPTH`=8:
  - The first byte pops, so the 9th is accepted and overflow stays 0.
  - A 10th push sets STATUS bit3 and count=8.
  - A write to +1 clears bit3.
- Pull `rst_n` low during DATA bit 3: `tx`=1 immediately. After release, STATUS=0x0002, FRAMES=0 and no residual frame follows.
- Write BAUD_DIV=7 mid-frame at div=3: the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
